ws2812_pattern_gen: RTL and testbench
=====================================

WS2812_PATTERN_GEN -- requirements
Module: ws2812_pattern_gen

Interface
REQ-001 The block SHALL provide parameter NUM_LED, default 8, giving the number of LEDs per frame (range 1..1024).
REQ-002 The block SHALL provide parameter FRAME_CYCLES, default 2_500_000, giving the frame period in clk cycles (50 ms at 50 MHz; minimum 2*NUM_LED+4).
REQ-003 The block SHALL provide parameter HUE_STEP, default 8, giving the hue offset between adjacent LEDs (range 0..191).
REQ-004 The block SHALL provide port clk, input, 1 bit, system clock at 50 MHz.
REQ-005 The block SHALL provide port rst_n, input, 1 bit, reset; rst_n is asynchronous and active-low, and clk is the clock.
REQ-006 The block SHALL provide port enable, input, 1 bit, which runs the frame timer when 1.
REQ-007 The block SHALL provide port mode, input, 2 bits, selecting the pattern: 0 OFF, 1 SOLID, 2 RAINBOW, 3 CHASE.
REQ-008 The block SHALL provide port color, input, 24 bits, giving the GRB colour used by SOLID and CHASE.
REQ-009 The block SHALL provide port brightness, input, 8 bits, giving the global scale.
REQ-010 The block SHALL provide port drv_busy, input, 1 bit, which is high while the downstream serializer is transmitting.
REQ-011 The block SHALL provide port frame_start, output, 1 bit, a one-cycle pulse at the start of each frame.
REQ-012 The block SHALL provide port pix_valid, output, 1 bit, which qualifies pix_data.
REQ-013 The block SHALL provide port pix_ready, input, 1 bit, the downstream accept signal.
REQ-014 The block SHALL provide port pix_data, output, 24 bits, carrying the pixel as {G,R,B}.
REQ-015 The block SHALL provide port pix_last, output, 1 bit, which is high with the pixel of index NUM_LED-1.

Function
REQ-016 The frame timer SHALL count 0..FRAME_CYCLES-1 while enable=1, wrap to 0, and set a single pending flag on wrap; pending events SHALL NOT accumulate.
REQ-017 When enable=0 the timer SHALL hold at 0, the pending flag SHALL clear, and any frame in progress SHALL complete normally.
REQ-018 The FSM SHALL have the states IDLE and STREAM.
REQ-019 In IDLE, when pending=1 and drv_busy=0, the FSM SHALL assert frame_start for that cycle, clear pending, sample mode, color and brightness into shadow registers, set the pixel index to 0, and enter STREAM.
REQ-020 In STREAM, pix_valid SHALL assert starting the cycle after frame_start.
REQ-021 In STREAM, a pixel SHALL transfer on each cycle where pix_valid and pix_ready are both 1; the index SHALL then increment, and the next pixel SHALL be presented with zero bubble cycles.
REQ-022 While pix_valid=1 and pix_ready=0, pix_data and pix_last SHALL be held stable.
REQ-023 On transfer of the pixel with index NUM_LED-1, pix_valid SHALL deassert the next cycle, the FSM SHALL return to IDLE, and the phase counters SHALL advance.
REQ-024 A timer wrap during STREAM or while drv_busy=1 SHALL only set pending; the frame is then deferred, not dropped.
REQ-025 Changes to mode, color or brightness mid-frame SHALL NOT affect the current frame.
REQ-026 hue_phase SHALL be 8 bits with range 0..191, SHALL increment by 1 per completed frame, and SHALL wrap 191->0.
REQ-027 chase_pos SHALL have range 0..NUM_LED-1, SHALL increment per completed frame, and SHALL wrap to 0.
REQ-028 In mode OFF, every pixel SHALL be 24'h000000.
REQ-029 In mode SOLID, every pixel SHALL be the sampled colour.
REQ-030 In mode CHASE, pixel chase_pos SHALL be the sampled colour and all other pixels SHALL be 0.
REQ-031 In mode RAINBOW, pixel i SHALL use hue h=(hue_phase+i*HUE_STEP) mod 192, with s=h/64 and f=(h mod 64)*4.
REQ-032 For the RAINBOW hue: s=0 SHALL give R=255-f, G=f, B=0; s=1 SHALL give R=0, G=255-f, B=f; s=2 SHALL give R=f, G=0, B=255-f.
REQ-033 Each channel after pattern selection SHALL be scaled as out=(c*(brightness+1))>>8 using a 17-bit product, truncated without rounding.
REQ-034 Brightness 255 SHALL leave the value unchanged, and brightness 0 with c=255 SHALL give 0.
REQ-035 The pixel pipeline latency SHALL be at most 1 register stage, hidden behind the pix_valid timing of REQ-020.
REQ-036 NUM_LED=1 SHALL assert pix_last on the only pixel and SHALL keep chase_pos at 0.

Reset
REQ-037 While rst_n=0 the block SHALL drive frame_start=0, pix_valid=0, pix_last=0 and pix_data=0.
REQ-038 While rst_n=0 the block SHALL set the timer=0, pending=0, hue_phase=0, chase_pos=0, the index=0, the shadow registers=0, and the FSM to IDLE.
REQ-039 Reset asserted mid-frame SHALL abort the frame immediately, with no further pixels.
REQ-040 After rst_n deasserts, the first frame_start SHALL occur FRAME_CYCLES cycles after enable=1 is first seen, provided drv_busy=0.

Verification
REQ-041 The bench SHALL cover: NUM_LED=8, FRAME_CYCLES=40, mode=1, color=24'h102030, brightness=255, pix_ready=1 -> frame_start every 40 cycles, 8 pixels of 24'h102030, pix_last on the 8th.
REQ-042 The bench SHALL cover: mode=2, HUE_STEP=8, hue_phase=0 -> pixel0={G=0,R=255,B=0}, pixel1={G=32,R=223,B=0}; the next frame's pixel0 is {G=4,R=251,B=0}.
REQ-043 The bench SHALL cover: mode=3, NUM_LED=4 over 5 frames -> the lit index follows 0,1,2,3,0.
REQ-044 The bench SHALL cover: brightness=127 with color=24'hFF80FF -> pixel=24'h7F407F.
REQ-045 The bench SHALL cover: random pix_ready backpressure plus drv_busy held high across 3 timer wraps -> pix_data stays stable while stalled, exactly one deferred frame_start occurs after drv_busy falls, and there are no lost or duplicated pixels.
REQ-046 The bench SHALL cover: rst_n pulsed low after the 3rd pixel -> pix_valid=0 the same cycle, and the next frame restarts at index 0 with hue_phase=0.

Source files
------------

// File: rtl/ws2812_pattern_gen.sv
// rtl/ws2812_pattern_gen.sv - WS2812 frame timer and pixel pattern generator (OFF/SOLID/RAINBOW/CHASE)
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   enable              runs the frame timer
//   mode                0 OFF, 1 SOLID, 2 RAINBOW, 3 CHASE
//   color               GRB colour for SOLID and CHASE
//   brightness          global channel scale, out = c*(brightness+1) >> 8
//   drv_busy            downstream serializer busy; holds off frame start
//   frame_start         one-cycle pulse when a frame begins
//   pix_valid/pix_ready pixel stream handshake
//   pix_data            pixel as {G,R,B}
//   pix_last            marks pixel NUM_LED-1
module ws2812_pattern_gen #(
    parameter int NUM_LED      = 8,
    parameter int FRAME_CYCLES = 2_500_000,
    parameter int HUE_STEP     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [23:0] color,
    input  logic [7:0]  brightness,
    input  logic        drv_busy,
    output logic        frame_start,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [23:0] pix_data,
    output logic        pix_last
);

    localparam int TW = $clog2(FRAME_CYCLES);
    localparam int IW = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(FRAME_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_LED - 1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] timer;
    logic          pending;
    logic [IW-1:0] idx;
    logic [IW-1:0] chase_pos;
    logic [7:0]    hue_phase;
    logic [7:0]    hue_cur;      // hue of the pixel currently presented
    logic [1:0]    mode_s;
    logic [23:0]   color_s;
    logic [7:0]    bright_s;

    logic          wrap;
    logic          xfer;
    logic          last_xfer;

    logic [1:0]    sel_mode;
    logic [23:0]   sel_color;
    logic [7:0]    sel_bright;
    logic [IW-1:0] sel_idx;
    logic [7:0]    sel_hue;
    logic [8:0]    hsum;
    logic [7:0]    hue_adv;
    logic [7:0]    frac;
    logic [7:0]    rb_r, rb_g, rb_b;
    logic [23:0]   pat;
    logic [23:0]   pix_next;

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [16:0] p;
        p = 17'(c) * 17'({1'b0, b} + 9'd1);
        return 8'(p >> 8);
    endfunction

    assign wrap      = enable && (timer == TIMER_MAX);
    assign pix_valid = (state == S_STREAM);
    assign pix_last  = pix_valid && (idx == LAST_IDX);

    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        xfer        = 1'b0;
        last_xfer   = 1'b0;
        case (state)
            S_IDLE: begin
                if (pending && !drv_busy) begin
                    frame_start = 1'b1;
                    state_next  = S_STREAM;
                end
            end
            S_STREAM: begin
                if (pix_ready) begin
                    xfer = 1'b1;
                    if (idx == LAST_IDX) begin
                        last_xfer  = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Next pixel to load into pix_data. On frame_start the shadow registers
    // are being loaded in the same edge, so pixel 0 uses the live inputs.
    // Hue is advanced incrementally per pixel to avoid a modulo-192 multiplier.
    always_comb begin
        sel_mode   = frame_start ? mode       : mode_s;
        sel_color  = frame_start ? color      : color_s;
        sel_bright = frame_start ? brightness : bright_s;
        sel_idx    = frame_start ? '0         : idx + IW'(1);
        hsum       = {1'b0, hue_cur} + 9'(HUE_STEP);
        hue_adv    = (hsum >= 9'd192) ? 8'(hsum - 9'd192) : hsum[7:0];
        sel_hue    = frame_start ? hue_phase : hue_adv;
        frac       = {sel_hue[5:0], 2'b00};

        rb_r = 8'd0;
        rb_g = 8'd0;
        rb_b = 8'd0;
        case (sel_hue[7:6])
            2'd0: begin rb_r = 8'd255 - frac; rb_g = frac; end
            2'd1: begin rb_g = 8'd255 - frac; rb_b = frac; end
            2'd2: begin rb_r = frac; rb_b = 8'd255 - frac; end
            default: ;
        endcase

        pat = 24'h000000;
        case (sel_mode)
            2'd1:    pat = sel_color;
            2'd2:    pat = {rb_g, rb_r, rb_b};
            2'd3:    pat = (sel_idx == chase_pos) ? sel_color : 24'h000000;
            default: pat = 24'h000000;
        endcase

        pix_next = {scale(pat[23:16], sel_bright),
                    scale(pat[15:8],  sel_bright),
                    scale(pat[7:0],   sel_bright)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            timer     <= '0;
            pending   <= 1'b0;
            idx       <= '0;
            chase_pos <= '0;
            hue_phase <= 8'd0;
            hue_cur   <= 8'd0;
            mode_s    <= 2'd0;
            color_s   <= 24'h000000;
            bright_s  <= 8'd0;
            pix_data  <= 24'h000000;
        end else begin
            state <= state_next;

            if (!enable || wrap) begin
                timer <= '0;
            end else begin
                timer <= timer + TW'(1);
            end

            // A wrap wins over the clear so an event arriving on the start
            // edge is not lost; a single flag means events never stack.
            if (!enable) begin
                pending <= 1'b0;
            end else if (wrap) begin
                pending <= 1'b1;
            end else if (frame_start) begin
                pending <= 1'b0;
            end

            if (frame_start) begin
                mode_s   <= mode;
                color_s  <= color;
                bright_s <= brightness;
                idx      <= '0;
                hue_cur  <= hue_phase;
                pix_data <= pix_next;
            end else if (last_xfer) begin
                idx       <= '0;
                pix_data  <= 24'h000000;
                hue_phase <= (hue_phase == 8'd191) ? 8'd0 : hue_phase + 8'd1;
                chase_pos <= (chase_pos == LAST_IDX) ? '0 : chase_pos + IW'(1);
            end else if (xfer) begin
                idx      <= idx + IW'(1);
                hue_cur  <= hue_adv;
                pix_data <= pix_next;
            end
        end
    end

endmodule

// File: tb/tb_ws2812_pattern_gen.sv
// tb/tb_ws2812_pattern_gen.sv - scoreboard testbench for ws2812_pattern_gen
module tb_ws2812_pattern_gen;

    localparam int NL = 8;
    localparam int FC = 40;
    localparam int HS = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  mode;
    logic [23:0] color;
    logic [7:0]  brightness;
    logic        drv_busy;
    logic        pix_ready;
    logic        frame_start, pix_valid, pix_last;
    logic [23:0] pix_data;
    logic        fs4, pv4, pl4;
    logic [23:0] pd4;

    ws2812_pattern_gen #(.NUM_LED(NL), .FRAME_CYCLES(FC), .HUE_STEP(HS)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .color(color),
        .brightness(brightness), .drv_busy(drv_busy), .frame_start(frame_start),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_last(pix_last)
    );

    ws2812_pattern_gen #(.NUM_LED(4), .FRAME_CYCLES(FC), .HUE_STEP(HS)) dut4 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .color(color),
        .brightness(brightness), .drv_busy(drv_busy), .frame_start(fs4),
        .pix_valid(pv4), .pix_ready(pix_ready), .pix_data(pd4), .pix_last(pl4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] data;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          fs_count = 0;
    int          fs_cyc = 0;
    int          ref_hue = 0;
    int          ref_chase = 0;
    int          ref_chase4 = 0;
    int          idx4 = 0;
    int          frames4 = 0;
    int          xfer_in_frame = 0;
    bit          fs_prev = 0;
    bit          period_chk = 0;
    bit          rand_ready = 0;
    bit          track4 = 0;
    bit          log_en = 0;
    int          lit_log[$];
    logic [23:0] log_pix[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [23:0] model_pix(input int m, input logic [23:0] c, input int b,
                                              input int i, input int hp, input int cp);
        int h, s, f, r, g, bl, gg, rr, bb;
        logic [23:0] p;
        case (m)
            0: p = 24'h0;
            1: p = c;
            3: p = (i == cp) ? c : 24'h0;
            default: begin
                h = (hp + i * HS) % 192;
                s = h / 64;
                f = (h % 64) * 4;
                if (s == 0)      begin r = 255 - f; g = f;       bl = 0;       end
                else if (s == 1) begin r = 0;       g = 255 - f; bl = f;       end
                else             begin r = f;       g = 0;       bl = 255 - f; end
                p = {8'(g), 8'(r), 8'(bl)};
            end
        endcase
        gg = p[23:16];
        rr = p[15:8];
        bb = p[7:0];
        return {8'((gg * (b + 1)) >> 8), 8'((rr * (b + 1)) >> 8), 8'((bb * (b + 1)) >> 8)};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Main scoreboard: expectations pushed on frame_start, popped on transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            ref_hue = 0;
            ref_chase = 0;
            fs_prev = 0;
        end else begin
            if (fs_prev) check("valid_after_fs", pix_valid, 1'b1);
            if (pix_valid) begin
                if (sb.size() == 0) begin
                    check("no_extra_pixel", pix_valid, 1'b0);
                end else begin
                    check("pix_data", pix_data, sb[0].data);
                    check("pix_last", pix_last, sb[0].last);
                    if (pix_ready) begin
                        e = sb.pop_front();
                        xfer_in_frame++;
                        if (log_en) log_pix.push_back(pix_data);
                        if (e.last) begin
                            ref_hue = (ref_hue + 1) % 192;
                            ref_chase = (ref_chase + 1) % NL;
                        end
                    end
                end
            end
            fs_prev = frame_start;
            if (frame_start) begin
                check("sb_empty_at_fs", sb.size(), 0);
                if (period_chk) check("fs_period", cyc - fs_cyc, FC);
                for (int i = 0; i < NL; i++) begin
                    e.data = model_pix(int'(mode), color, int'(brightness), i, ref_hue, ref_chase);
                    e.last = (i == NL - 1);
                    sb.push_back(e);
                end
                fs_count++;
                fs_cyc = cyc;
                xfer_in_frame = 0;
            end
        end
    end

    // Four-LED instance: chase position tracking.
    always @(negedge clk) begin
        if (!rst_n) begin
            ref_chase4 = 0;
            idx4 = 0;
        end else if (pv4 && pix_ready) begin
            if (track4) begin
                check("c4_data", pd4, (idx4 == ref_chase4) ? color : 24'h0);
                check("c4_last", pl4, idx4 == 3);
                if (pd4 != 24'h0) lit_log.push_back(idx4);
            end
            if (idx4 == 3) begin
                idx4 = 0;
                ref_chase4 = (ref_chase4 + 1) % 4;
                frames4++;
            end else begin
                idx4++;
            end
        end
    end

    task automatic wait_fs(input int n, input int budget);
        for (int k = 0; k < budget && fs_count < n; k++) @(negedge clk);
        check("wait_fs", fs_count >= n, 1'b1);
    endtask

    task automatic wait_drain(input int budget);
        for (int k = 0; k < budget && (sb.size() != 0 || pix_valid); k++) @(negedge clk);
        check("drain", sb.size(), 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int e_cyc, c0, d_cyc, base;
        rst_n = 1'b0; enable = 1'b0; mode = 2'd0; color = 24'h0;
        brightness = 8'd255; drv_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_frame_start", frame_start, 1'b0);
        check("rst_pix_valid", pix_valid, 1'b0);
        check("rst_pix_last", pix_last, 1'b0);
        check("rst_pix_data", pix_data, 24'h0);
        rst_n = 1'b1;

        // SOLID, first frame latency and steady period
        mode = 2'd1; color = 24'h102030;
        @(posedge clk); #1;
        enable = 1'b1;
        e_cyc = cyc;
        wait_fs(1, 100);
        check("first_fs_delay", fs_cyc - e_cyc, FC);
        period_chk = 1;
        wait_fs(4, 200);
        period_chk = 0;

        // Mode change mid-frame must not affect the frame in flight
        wait_fs(fs_count + 1, 100);
        @(posedge clk); #1;
        mode = 2'd2;
        wait_fs(fs_count + 2, 200);

        // Brightness scaling
        mode = 2'd1; color = 24'hFF80FF; brightness = 8'd127;
        wait_drain(50);
        wait_fs(fs_count + 2, 200);
        wait_drain(50);
        check("scaled_solid", model_pix(1, 24'hFF80FF, 127, 0, 0, 0), 24'h7F407F);

        // CHASE on both instances from a clean reset
        mode = 2'd3; color = 24'h0A0B0C; brightness = 8'd255;
        pulse_reset();
        frames4 = 0;
        track4 = 1;
        for (int k = 0; k < 600 && frames4 < 5; k++) @(negedge clk);
        track4 = 0;
        check("chase_frames", lit_log.size(), 5);
        for (int k = 0; k < 5 && k < lit_log.size(); k++) check("chase_lit", lit_log[k], k % 4);
        wait_drain(50);

        // Backpressure plus drv_busy across three wraps
        mode = 2'd2; brightness = 8'd200; rand_ready = 1;
        wait_fs(fs_count + 1, 100);
        @(posedge clk); #1;
        drv_busy = 1'b1;
        c0 = fs_count;
        repeat (125) @(posedge clk);
        #1;
        check("busy_no_fs", fs_count - c0, 0);
        drv_busy = 1'b0;
        d_cyc = cyc;
        c0 = fs_count;
        repeat (30) @(posedge clk);
        #1;
        check("one_deferred_fs", fs_count - c0, 1);
        check("deferred_fs_delay", fs_cyc - d_cyc, 0);
        rand_ready = 0;
        wait_drain(200);

        // Reset after the third pixel of a rainbow frame
        mode = 2'd2; brightness = 8'd255;
        wait_fs(fs_count + 1, 100);
        for (int k = 0; k < 50 && xfer_in_frame < 3; k++) @(negedge clk);
        check("three_pixels", xfer_in_frame, 3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", pix_valid, 1'b0);
        check("rst_mid_data", pix_data, 24'h0);
        check("rst_mid_last", pix_last, 1'b0);
        @(posedge clk); #1;
        log_pix.delete();
        log_en = 1;
        rst_n = 1'b1;
        base = fs_count;
        for (int k = 0; k < 200 && log_pix.size() < 2 * NL; k++) @(negedge clk);
        log_en = 0;
        check("post_rst_frames", fs_count - base, 2);
        check("post_rst_pixels", log_pix.size(), 2 * NL);
        if (log_pix.size() >= 2 * NL) begin
            check("rb_f0_p0", log_pix[0], 24'h00FF00);
            check("rb_f0_p1", log_pix[1], 24'h20DF00);
            check("rb_f1_p0", log_pix[NL], 24'h04FB00);
        end
        wait_drain(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
